// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: redirect/stall controls in, fetch address and slot tag out.
// The master drives the redirect controls; the slave is the sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned AW = 16
);
  logic          stall;
  logic          kill;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          jump_valid;
  logic          jump_link;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] link_addr;
  logic          ret;
  logic [AW-1:0] pc;
  logic          inst_valid;
  logic [AW-1:0] inst_pc;
  logic          ras_overflow;
  logic          ras_underflow;

  modport master (
    output stall, kill, branch_taken, branch_target, jump_valid, jump_link,
           jump_target, link_addr, ret,
    input  pc, inst_valid, inst_pc, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, kill, branch_taken, branch_target, jump_valid, jump_link,
           jump_target, link_addr, ret,
    output pc, inst_valid, inst_pc, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC controller for a registered-read instruction memory, with a circular
// return-address stack and a valid/PC tag aligned to the memory output slot.
module fetch_sequencer #(
  parameter int unsigned    AW        = 16,
  parameter int unsigned    RAS_DEPTH = 8,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_sequencer_if.slave     bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  logic          push_c;
  logic [PW-1:0] push_ptr_c;
  logic          ras_full_c;
  logic          ras_empty_c;

  assign push_ptr_c  = top_q + PW'(1);
  assign ras_full_c  = (count_q == CW'(RAS_DEPTH));
  assign ras_empty_c = (count_q == '0);

  // Next-state selection: branch > ret > jump, then stall, then sequential.
  always_comb begin
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    top_d        = top_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    push_c       = 1'b0;

    if (bus.branch_taken) begin
      pc_d         = bus.branch_target;
      inst_valid_d = 1'b0;
    end else if (bus.ret) begin
      inst_valid_d = 1'b0;
      if (ras_empty_c) begin
        pc_d  = RESET_PC;
        unf_d = 1'b1;
      end else begin
        pc_d    = ras_q[top_q];
        top_d   = top_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end else if (bus.jump_valid) begin
      pc_d         = bus.jump_target;
      inst_valid_d = 1'b0;
      if (bus.jump_link) begin
        push_c = 1'b1;
        top_d  = push_ptr_c;
        // A full stack drops its oldest entry, which sits exactly at top+1.
        if (ras_full_c) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end else if (bus.stall) begin
      if (bus.kill) begin
        inst_valid_d = 1'b0;
      end
    end else begin
      pc_d         = pc_q + AW'(1);
      inst_pc_d    = pc_q;
      inst_valid_d = ~bus.kill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      top_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      top_q        <= top_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Stack storage needs no reset; count_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      ras_q[push_ptr_c] <= bus.link_addr;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue-based reference model predicts
// the post-edge state each cycle and a negedge monitor compares it.
module tb_fetch_sequencer;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    logic        iv;
    logic [15:0] ipc;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_sequencer_if #(.AW(AW)) bus ();

  fetch_sequencer #(.AW(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [15:0] m_ras[$];
  logic [15:0] m_pc;
  logic        m_iv;
  logic [15:0] m_ipc;
  logic        m_ovf;
  logic        m_unf;
  logic        started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Reference model: stack is a plain queue, newest at the back.
  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      started = 1'b1;
      m_pc = RST_PC; m_iv = 1'b0; m_ipc = 16'h0000;
      m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (started) begin
      if (bus.branch_taken) begin
        m_pc = bus.branch_target; m_iv = 1'b0;
      end else if (bus.ret) begin
        m_iv = 1'b0;
        if (m_ras.size() == 0) begin
          m_pc = RST_PC; m_unf = 1'b1;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else if (bus.jump_valid) begin
        m_pc = bus.jump_target; m_iv = 1'b0;
        if (bus.jump_link) begin
          m_ras.push_back(bus.link_addr);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
      end else if (bus.stall) begin
        if (bus.kill) m_iv = 1'b0;
      end else begin
        m_ipc = m_pc;
        m_pc  = m_pc + 16'd1;
        m_iv  = ~bus.kill;
      end
    end
    if (started) begin
      e.pc = m_pc; e.iv = m_iv; e.ipc = m_ipc; e.ovf = m_ovf; e.unf = m_unf;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every presented slot against the predicted state.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",            32'(bus.pc),            32'(e.pc));
      chk("inst_valid",    32'(bus.inst_valid),    32'(e.iv));
      if (e.iv) chk("inst_pc", 32'(bus.inst_pc),   32'(e.ipc));
      else      chk("inst_pc_hold", 32'(bus.inst_pc), 32'(e.ipc));
      chk("ras_overflow",  32'(bus.ras_overflow),  32'(e.ovf));
      chk("ras_underflow", 32'(bus.ras_underflow), 32'(e.unf));
    end
  end

  task automatic drive(input logic rs, input logic st, input logic kl,
                       input logic br, input logic [15:0] bt,
                       input logic rt, input logic jv, input logic jl,
                       input logic [15:0] jt, input logic [15:0] la);
    reset = rs;
    bus.stall = st; bus.kill = kl;
    bus.branch_taken = br; bus.branch_target = bt;
    bus.ret = rt;
    bus.jump_valid = jv; bus.jump_link = jl;
    bus.jump_target = jt; bus.link_addr = la;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    bus.stall = 0; bus.kill = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.ret = 0; bus.jump_valid = 0; bus.jump_link = 0;
    bus.jump_target = '0; bus.link_addr = '0;

    drive(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    chk("reset_pc", 32'(bus.pc), 32'h0);
    chk("reset_valid", 32'(bus.inst_valid), 32'h0);
    idle(3);
    // stall at pc=3 for 3 cycles, kill in the last
    drive(0, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    drive(0, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    drive(0, 1, 1, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    chk("stall_pc_held", 32'(bus.pc), 32'h3);
    idle(2);
    // jump to 0x000A
    drive(0, 0, 0, 0, 16'h0, 0, 1, 0, 16'h000A, 16'h0);
    idle(1);
    chk("jump_tag", 32'({bus.inst_valid, bus.inst_pc}), 32'h1000A);
    idle(2);
    // CALL then ret three cycles later
    drive(0, 0, 0, 0, 16'h0, 0, 1, 1, 16'h0020, 16'h0006);
    idle(2);
    drive(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0);
    chk("ret_pc", 32'(bus.pc), 32'h6);
    idle(2);
    // branch + ret + jump together: branch wins, stack untouched
    drive(0, 0, 0, 1, 16'h0040, 1, 1, 1, 16'h0099, 16'h0077);
    chk("prio_pc", 32'(bus.pc), 32'h40);
    idle(1);
    // 9 calls into a depth-8 stack, then 9 rets
    for (int i = 1; i <= 9; i++)
      drive(0, 0, 0, 0, 16'h0, 0, 1, 1, 16'h0100 + 16'(i), 16'(i));
    for (int i = 9; i >= 1; i--) begin
      drive(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0);
      chk("pop_target", 32'(bus.pc), (i >= 2) ? 32'(i) : 32'(RST_PC));
    end
    chk("ovf_set", 32'(bus.ras_overflow), 32'h1);
    chk("unf_set", 32'(bus.ras_underflow), 32'h1);
    // reset mid-redirect
    drive(1, 0, 0, 0, 16'h0, 0, 1, 1, 16'h0055, 16'h0033);
    chk("rst_flags", 32'({bus.ras_overflow, bus.ras_underflow}), 32'h0);
    chk("rst_pc2", 32'(bus.pc), 32'h0);
    idle(2);
    // address wrap
    drive(0, 0, 0, 1, 16'hFFFE, 0, 0, 0, 16'h0, 16'h0);
    idle(4);
    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic rs, st, kl, br, rt, jv, jl;
      rs = ($urandom_range(199, 0) == 0);
      st = ($urandom_range(99, 0) < 25);
      kl = ($urandom_range(99, 0) < 10);
      br = ($urandom_range(99, 0) < 8);
      rt = ($urandom_range(99, 0) < 12);
      jv = ($urandom_range(99, 0) < 14);
      jl = ($urandom_range(99, 0) < 65);
      drive(rs, st, kl, br, 16'($urandom), rt, jv, jl, 16'($urandom), 16'($urandom));
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller for the instruction memory (registered read: address sampled at posedge, instruction valid the following cycle).
- Drives the fetch address and selects the next PC from sequential, branch, jump/call or return sources; holds a circular return-address stack (RAS) for call/RET.
- Produces a valid flag and PC tag aligned with the instruction leaving memory, so decode can discard squashed slots.
- Sits between the decode/execute redirect logic and the instruction memory; shares its stall and kill with the memory.

Parameters:
- AW, 16, PC/address width.
- RAS_DEPTH, 8, number of return-stack entries (power of two, at least 2).
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and output slot; same signal drives memory stall.
- kill  input  1  squash the instruction currently in flight.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  AW  branch destination.
- jump_valid  input  1  redirect to jump_target (JMP/CALL).
- jump_link  input  1  with jump_valid: push link_addr onto RAS (CALL).
- jump_target  input  AW  jump destination.
- link_addr  input  AW  return address for CALL (call PC + 1).
- ret  input  1  redirect to popped RAS top.
- pc  output  AW  fetch address to instruction memory.
- inst_valid  output  1  memory output this cycle is a live instruction.
- inst_pc  output  AW  PC of the instruction on memory output.
- ras_overflow  output  1  sticky: push into a full RAS occurred.
- ras_underflow  output  1  sticky: pop from an empty RAS occurred.

Behaviour:
- Reset values (reset sampled high at posedge): pc=RESET_PC, inst_valid=0, inst_pc=0, RAS count=0, top pointer=0, both sticky flags=0. Reset wins over all other inputs, including mid-redirect.
- Redirect priority, one winner per cycle: branch_taken > ret > jump_valid. Losing requests are ignored entirely; no RAS side effect.
- Next-state rules, evaluated on each posedge when not in reset:
  - Redirect: pc <= target, inst_valid <= 0, inst_pc unchanged. Redirect overrides stall; the wrong-path fetch of the old pc is squashed.
  - Else stall: pc, inst_pc and inst_valid hold. Exception: kill forces inst_valid <= 0.
  - Else normal: pc <= pc+1 (mod 2^AW; 16'hFFFF wraps to 0), inst_pc <= pc, inst_valid <= !kill.
- Latency: first instruction (address RESET_PC) is valid 1 cycle after reset deasserts. A redirect issued in cycle N produces the target instruction valid in cycle N+2.
- RAS is a circular buffer with count 0..RAS_DEPTH.
  - Push (jump_valid & jump_link winning): write link_addr at top+1, top++. If count==RAS_DEPTH, overwrite the oldest entry, count stays RAS_DEPTH, set ras_overflow.
  - Pop (ret winning): target = entry[top], top--, count--. If count==0, target = RESET_PC, pointers unchanged, set ras_underflow.
  - Push and pop can never occur in the same cycle, because of redirect priority.
- Sticky flags clear only on reset.
- kill without a redirect squashes only the in-flight slot; PC sequencing continues.

Test Plan:
- Reset, then 5 free cycles, no stall -> pc 0,1,2,3,4,5; inst_valid rises 1 cycle after reset with inst_pc 0,1,2,3,4.
- stall high for 3 cycles at pc=3 -> pc, inst_pc=2 and inst_valid=1 held for 3 cycles; resumes at pc=4. Kill during the stall -> inst_valid=0 from the next cycle.
- jump_valid, jump_target=16'h000A at pc=2 -> next pc=10, inst_valid=0 for 1 cycle, then inst_pc=10 valid 2 cycles after the request.
- CALL (jump_link, link_addr=16'h0006, target 16'h0020), then ret 3 cycles later -> pc=16'h0020, then 21, 22, then pc=6; ras_underflow stays 0.
- branch_taken (target 16'h0040) + ret + jump_valid in the same cycle -> pc=16'h0040; RAS count unchanged.
- 9 pushes with RAS_DEPTH=8 (links 1..9), then 9 rets -> pops 9..2, ras_overflow=1; the 9th ret targets RESET_PC and sets ras_underflow=1. Reset mid-sequence -> both flags 0, pc=0.
